// File: rtl/multicycle_control.sv
// Moore-style sequencing FSM for a multicycle MIPS datapath (shared memory, one ALU, IR, ALUOut).
// Fetch is Mealy on mem_ready_i; memory states stall until ready; unknown opcodes park in ILLEGAL.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter logic [2:0] ALU_ADD     = 3'b100,
  parameter logic [2:0] ALU_SUB     = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       branch_eq_o,
  output logic       branch_ne_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    WB_R      = 4'd7,
    EXEC_I    = 4'd8,
    WB_I      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    ILLEGAL   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b000;

  state_t state_reg, state_next;
  logic   illegal_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= state_t'(RESET_STATE);
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == ILLEGAL)
        illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_src_o     = 2'b00;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    retire_o     = 1'b0;

    case (state_reg)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALU_ADD;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Speculatively form the branch target so BRANCH can load it from ALUOut.
        alu_src_b_o = 2'b11;
        alu_op_o    = ALU_ADD;
        case (opcode_i)
          OP_RTYPE:              state_next = EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI: state_next = EXEC_I;
          OP_LW, OP_SW:          state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:        state_next = BRANCH;
          OP_J:                  state_next = JUMP;
          default:               state_next = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALU_ADD;
        state_next  = (opcode_i == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i)
          state_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_o     = 1'b1;
        state_next   = FETCH;
      end
      MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          retire_o   = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_RTYPE;
        state_next  = WB_R;
      end
      WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire_o    = 1'b1;
        state_next  = FETCH;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          OP_ORI:  alu_op_o = ALU_OR;
          OP_LUI:  alu_op_o = ALU_LUI;
          default: alu_op_o = ALU_ADD;
        endcase
        state_next = WB_I;
      end
      WB_I: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = 2'b01;
        branch_eq_o = (opcode_i == OP_BEQ);
        branch_ne_o = (opcode_i == OP_BNE);
        retire_o    = 1'b1;
        state_next  = FETCH;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        retire_o   = 1'b1;
        state_next = FETCH;
      end
      ILLEGAL: state_next = ILLEGAL;
      // Unused encodings recover to a clean fetch.
      default: state_next = FETCH;
    endcase
  end

  assign illegal_o = illegal_reg;
  assign state_o   = state_reg;

endmodule
